// File: rtl/unit_a.sv
// unit_a: 32-bit registered arithmetic slice (add, sub, ~A+B, inc) with
// carry-out and signed overflow; one shared adder, all outputs registered.
module unit_a (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  f,
    output logic [31:0] S,
    output logic        c_out,
    output logic        O
);

    typedef enum logic [1:0] {
        OP_SUM  = 2'b00,
        OP_SUB  = 2'b01,
        OP_AINV = 2'b10,
        OP_INC  = 2'b11
    } op_e;

    // No handshake: a new operation is accepted on every rising edge and its
    // result appears on S/c_out/O exactly one edge later.

    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [31:0] w_s_n;
    logic        w_c_n;
    logic        w_o_n;

    // Operand steering; inc forces Y to zero so B never reaches the adder.
    always_comb begin
        w_x   = A;
        w_y   = B;
        w_cin = 1'b0;
        case (op_e'(f))
            OP_SUM: begin
                w_x   = A;
                w_y   = B;
                w_cin = 1'b0;
            end
            OP_SUB: begin
                w_x   = A;
                w_y   = ~B;
                w_cin = 1'b1;
            end
            OP_AINV: begin
                w_x   = ~A;
                w_y   = B;
                w_cin = 1'b0;
            end
            OP_INC: begin
                w_x   = A;
                w_y   = 32'h0;
                w_cin = 1'b1;
            end
            default: begin
                w_x   = A;
                w_y   = B;
                w_cin = 1'b0;
            end
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'h0, w_cin};
    assign w_s_n = w_sum[31:0];
    assign w_c_n = w_sum[32];

    // Overflow judged on the post-inversion adder operands, not on A/B.
    assign w_o_n = (w_x[31] == w_y[31]) & (w_s_n[31] != w_x[31]);

    logic [31:0] r_s;
    logic        r_c;
    logic        r_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= 32'h0;
            r_c <= 1'b0;
            r_o <= 1'b0;
        end else begin
            r_s <= w_s_n;
            r_c <= w_c_n;
            r_o <= w_o_n;
        end
    end

    assign S     = r_s;
    assign c_out = r_c;
    assign O     = r_o;

endmodule

// File: tb/tb_unit_a.sv
// Directed bench for unit_a: hand-computed vectors checked with immediate
// assertions one cycle after each operation is applied.
module tb_unit_a;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  f;
    logic [31:0] S;
    logic        c_out;
    logic        O;

    int n_checks;
    int n_fail;

    logic [33:0] exp_q[$];

    unit_a dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .f     (f),
        .S     (S),
        .c_out (c_out),
        .O     (O)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_one(input string tag, input logic [33:0] exp);
        n_checks++;
        assert ({S, c_out, O} === exp) else begin
            n_fail++;
            $error("FAIL %s: got S=%08h c=%0b O=%0b, expected S=%08h c=%0b O=%0b",
                   tag, S, c_out, O, exp[33:2], exp[1], exp[0]);
        end
    endtask

    // Drive at the falling edge, clock once, check just after the rising edge.
    task automatic op(input string tag, input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] fn,
                      input logic [31:0] es, input logic ec, input logic eo);
        logic [33:0] exp;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        f   = fn;
        exp_q.push_back({es, ec, eo});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check_one(tag, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        A   = 32'h0;
        B   = 32'h0;
        f   = 2'b00;

        op("reset_1", 1'b1, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0);
        op("reset_2", 1'b1, 32'h1234_5678, 32'h1, 2'b00, 32'h0, 1'b0, 1'b0);

        op("sum_6_6",  1'b0, 32'd6, 32'd6, 2'b00, 32'd12, 1'b0, 1'b0);
        op("sub_6_6",  1'b0, 32'd6, 32'd6, 2'b01, 32'd0,  1'b1, 1'b0);
        op("ainv_0_6", 1'b0, 32'd0, 32'd6, 2'b10, 32'd5,  1'b1, 1'b0);
        op("inc_0",    1'b0, 32'd0, 32'd6, 2'b11, 32'd1,  1'b0, 1'b0);

        op("sum_max_1", 1'b0, 32'h7FFF_FFFF, 32'h1, 2'b00, 32'h8000_0000, 1'b0, 1'b1);
        op("sub_max_1", 1'b0, 32'h7FFF_FFFF, 32'h1, 2'b01, 32'h7FFF_FFFE, 1'b1, 1'b0);
        op("sub_max_m1", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h8000_0000, 1'b0, 1'b1);
        op("ainv_max_min", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 32'h0, 1'b1, 1'b1);
        op("rst_wins", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 32'h0, 1'b0, 1'b0);

        // Unsigned borrow case: 3 - 5 wraps, no carry, no signed overflow.
        op("sub_3_5", 1'b0, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op("sum_wrap", 1'b0, 32'hFFFF_FFFF, 32'h1, 2'b00, 32'h0, 1'b1, 1'b0);
        op("sum_negov", 1'b0, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0, 1'b1, 1'b1);
        op("inc_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b11, 32'h0, 1'b1, 1'b0);
        op("inc_max", 1'b0, 32'h7FFF_FFFF, 32'h0, 2'b11, 32'h8000_0000, 1'b0, 1'b1);
        op("inc_b_x", 1'b0, 32'd41, 32'hxxxx_xxxx, 2'b11, 32'd42, 1'b0, 1'b0);
        op("ainv_5_3", 1'b0, 32'd5, 32'd3, 2'b10, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // Inputs changed mid-cycle must not disturb the registered outputs.
        #2;
        A = 32'hDEAD_BEEF;
        B = 32'h1;
        f = 2'b00;
        #1;
        check_one("hold_mid_cycle", {32'hFFFF_FFFD, 1'b0, 1'b0});
        op("after_hold", 1'b0, 32'hDEAD_BEEF, 32'h1, 2'b00, 32'hDEAD_BEF0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
